cps2_linedoubler: RTL and testbench
===================================

# cps2_linedoubler

Line doubler directly downstream of the CPS2 capture frontend. Stores each active 384-pixel input line (4-bit R/G/B/F) in a ping-pong line buffer and replays it twice on the following input line at one pixel per PCLK2x_i cycle. The 15.7 kHz CPS2 stream becomes 31.4 kHz output timing for the scaler/HDMI path. An optional scanline mode blanks the second replay.

## Interface
Parameters:
- H_TOTAL_OUT, 512: clocks per output line (half an input line).
- H_SYNCLEN, 36: output hsync length, clocks.
- H_BACKPORCH, 61: output back porch, clocks.
- H_ACTIVE, 384: active pixels per line, also the buffer depth per bank.
- V_SYNCLEN, 3: vsync length in input lines, which is 6 output lines.

Ports (clock, reset first):
- PCLK2x_i  in  1  sole clock; the input pixel rate is half this clock.
- RESET_N_i  in  1  reset, synchronous and active-low.
- R_i, G_i, B_i, F_i  in  4 each  frontend pixel.
- HSYNC_i, VSYNC_i  in  1 each  frontend syncs, active low.
- DE_i  in  1  frontend data enable.
- xpos_i  in  9  frontend active pixel index.
- scanline_en_i  in  1  blank the second replay.
- R_o, G_o, B_o, F_o  out  4 each  doubled pixel.
- HSYNC_o, VSYNC_o  out  1 each  output syncs, active low.
- DE_o  out  1  output data enable.
- xpos_o  out  9  output pixel index, 0..383.
- repeat_o  out  1  0 on first replay, 1 on second.

## Operation
**Buffer**
- Two banks × 384 words × 16 bits {R,G,B,F}, single-clock RAM with registered read.
- Write: each cycle with DE_i=1 and xpos_i<384, write {R_i,G_i,B_i,F_i} to wr_bank[xpos_i]. Each pixel is written twice, which is harmless. Writes with xpos_i≥384 are dropped.
- `wrote` flag: set on any accepted write.

**Input line start:** HSYNC_i falling edge. HSYNC_i_prev is registered, so the edge is detected when HSYNC_i_prev=1 and HSYNC_i=0. On that edge:
- rd_bank←wr_bank; wr_bank←~wr_bank.
- rd_valid←wrote; wrote←0. If a write coincides with the edge, the write goes to the old bank and the flag is consumed.
- oh←0, repeat←0.
- Vertical: if VSYNC_i_prev=1 and VSYNC_i=0, then iv←0; otherwise iv←iv+1, saturating at 511. VSYNC_i_prev updates only here.

**Output counter**
- oh increments every cycle.
- At oh=H_TOTAL_OUT-1: oh←0 and repeat←~repeat.
- If that wrap happens with repeat=1 (freewheel, no input hsync), rd_valid←0.
- An input hsync arriving mid-line truncates the current output line.

**Output pixels**
- Read address = oh-(H_SYNCLEN+H_BACKPORCH) while oh ∈ [97,481).
- Pixel out = RAM data. Force RGBF=0 if scanline_en_i=1 and repeat=1 (DE stays high).
- hsync_n = ~(oh<H_SYNCLEN).
- vsync_n = ~(iv<V_SYNCLEN).
- de = rd_valid & oh∈[97,481).

## Timing
- Two-stage pipeline: RAM read register, then output register. HSYNC_o, VSYNC_o, DE_o, xpos_o and repeat_o are delayed two cycles from oh/iv so they stay aligned with pixel data.
- Input pixel xpos=x of line n appears on line n+1 at output clock 97+x of both replays.
- Output line start (HSYNC_o fall) is 3 edges after the HSYNC_i falling edge is presented: edge detect, then oh=0, then two pipeline stages. Constant offset.
- DE_o is high for exactly 384 consecutive cycles per output line when rd_valid=1.
- Reset (RESET_N_i=0 at a clock edge):
  - All RGBF/DE_o/xpos_o/repeat_o = 0; HSYNC_o = VSYNC_o = 1.
  - oh=0, iv=511, wr_bank=0, rd_valid=0, wrote=0.
  - RAM contents are not cleared. DE_o stays low until one full input line has been written, so stale data is never shown.
- Reset mid-line: the next HSYNC_i fall restarts cleanly, and the first DE_o appears on the line after that.

## Test plan
- **Basic doubling:** Frontend-style stream, 1024 clk/line, DE at clocks 194..961, pixel value = xpos. Each input line yields two output lines, HSYNC_o period 512 clocks. DE_o runs 384 cycles carrying 0..383, with identical data on repeat_o=0 and repeat_o=1.
- **Latency/banking:** Line n all 0xAAAA, line n+1 all 0x5555. During line n+1 the output shows 0xAAAA twice. During line n+2 it shows 0x5555 twice. No mixing.
- **Scanline mode:** scanline_en_i=1. Repeat 0 carries data; repeat 1 has RGBF=0 with DE_o still high for 384 cycles.
- **Vsync:** VSYNC_i low across an hsync edge gives VSYNC_o low for exactly 6 output lines (3072 clocks), starting aligned with HSYNC_o.
- **Freewheel/truncation:** Remove HSYNC_i. Output continues at 512-clock lines, with DE_o on exactly two lines and then low. An early HSYNC_i at oh=200 restarts oh, and HSYNC_o falls 3 edges later.
- **Reset:** Assert RESET_N_i mid-active-line. Outputs take their reset values on the next edge. After release, DE_o stays low until the second HSYNC_i fall; writes with xpos_i≥384 never appear.

Source files
------------

// File: rtl/cps2_linedoubler.sv
// Line doubler behind the CPS2 capture frontend: each active input line is
// stored in a ping-pong buffer and replayed twice at PCLK2x rate.
module cps2_linedoubler #(
  parameter int H_TOTAL_OUT = 512,
  parameter int H_SYNCLEN   = 36,
  parameter int H_BACKPORCH = 61,
  parameter int H_ACTIVE    = 384,
  parameter int V_SYNCLEN   = 3
) (
  input  logic       PCLK2x_i,
  input  logic       RESET_N_i,
  input  logic [3:0] R_i,
  input  logic [3:0] G_i,
  input  logic [3:0] B_i,
  input  logic [3:0] F_i,
  input  logic       HSYNC_i,
  input  logic       VSYNC_i,
  input  logic       DE_i,
  input  logic [8:0] xpos_i,
  input  logic       scanline_en_i,
  output logic [3:0] R_o,
  output logic [3:0] G_o,
  output logic [3:0] B_o,
  output logic [3:0] F_o,
  output logic       HSYNC_o,
  output logic       VSYNC_o,
  output logic       DE_o,
  output logic [8:0] xpos_o,
  output logic       repeat_o
);

  localparam int OHW = $clog2(H_TOTAL_OUT);
  localparam int AW  = 9;

  localparam logic [OHW-1:0] OH_LAST  = OHW'(H_TOTAL_OUT - 1);
  localparam logic [OHW-1:0] OH_SYNC  = OHW'(H_SYNCLEN);
  localparam logic [OHW-1:0] OH_START = OHW'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [OHW-1:0] OH_END   = OHW'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [AW-1:0]  X_LIMIT  = AW'(H_ACTIVE);
  localparam logic [8:0]     IV_SYNC  = 9'(V_SYNCLEN);
  localparam logic [8:0]     IV_MAX   = 9'd511;

  logic [15:0] bank0 [H_ACTIVE];
  logic [15:0] bank1 [H_ACTIVE];
  logic [15:0] rd_data;

  logic           hsync_prev;
  logic           vsync_prev;
  logic           wr_bank;
  logic           rd_bank;
  logic           wrote;
  logic           rd_valid;
  logic           armed;
  logic           rep;
  logic [OHW-1:0] oh;
  logic [8:0]     iv;

  logic           hs_fall;
  logic           wr_en;
  logic           in_win;
  logic [AW-1:0]  x_cur;
  logic [15:0]    wr_data;

  logic           s1_hs;
  logic           s1_vs;
  logic           s1_de;
  logic           s1_rep;
  logic           s1_blank;
  logic [AW-1:0]  s1_x;

  assign hs_fall = hsync_prev & ~HSYNC_i;
  // Writes are held off after reset until a line start, so a partially
  // written line can never be promoted to the read bank.
  assign wr_en   = RESET_N_i & armed & DE_i & (xpos_i < X_LIMIT);
  assign wr_data = {R_i, G_i, B_i, F_i};
  assign in_win  = (oh >= OH_START) && (oh < OH_END);
  assign x_cur   = in_win ? AW'(oh - OH_START) : '0;

  always_ff @(posedge PCLK2x_i) begin
    if (wr_en) begin
      if (wr_bank) bank1[xpos_i] <= wr_data;
      else         bank0[xpos_i] <= wr_data;
    end
    rd_data <= rd_bank ? bank1[x_cur] : bank0[x_cur];
  end

  always_ff @(posedge PCLK2x_i) begin
    if (!RESET_N_i) begin
      hsync_prev <= 1'b1;
      vsync_prev <= 1'b1;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      wrote      <= 1'b0;
      rd_valid   <= 1'b0;
      armed      <= 1'b0;
      rep        <= 1'b0;
      oh         <= '0;
      iv         <= IV_MAX;
    end else begin
      hsync_prev <= HSYNC_i;
      if (hs_fall) begin
        rd_bank    <= wr_bank;
        wr_bank    <= ~wr_bank;
        rd_valid   <= wrote | wr_en;
        wrote      <= 1'b0;
        armed      <= 1'b1;
        oh         <= '0;
        rep        <= 1'b0;
        vsync_prev <= VSYNC_i;
        if (vsync_prev && !VSYNC_i) iv <= '0;
        else if (iv != IV_MAX)      iv <= iv + 9'd1;
      end else begin
        if (wr_en) wrote <= 1'b1;
        // Without an input hsync the second replay wraps into freewheel.
        if (oh == OH_LAST) begin
          oh  <= '0;
          rep <= ~rep;
          if (rep) rd_valid <= 1'b0;
        end else begin
          oh <= oh + OHW'(1);
        end
      end
    end
  end

  // Stage 1 runs alongside the RAM read, stage 2 drives the pins.
  always_ff @(posedge PCLK2x_i) begin
    if (!RESET_N_i) begin
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_de    <= 1'b0;
      s1_rep   <= 1'b0;
      s1_blank <= 1'b0;
      s1_x     <= '0;
      R_o      <= '0;
      G_o      <= '0;
      B_o      <= '0;
      F_o      <= '0;
      HSYNC_o  <= 1'b1;
      VSYNC_o  <= 1'b1;
      DE_o     <= 1'b0;
      xpos_o   <= '0;
      repeat_o <= 1'b0;
    end else begin
      s1_hs    <= ~(oh < OH_SYNC);
      s1_vs    <= ~(iv < IV_SYNC);
      s1_de    <= rd_valid & in_win;
      s1_rep   <= rep;
      s1_blank <= scanline_en_i & rep;
      s1_x     <= x_cur;
      {R_o, G_o, B_o, F_o} <= s1_blank ? 16'h0000 : rd_data;
      HSYNC_o  <= s1_hs;
      VSYNC_o  <= s1_vs;
      DE_o     <= s1_de;
      xpos_o   <= s1_x;
      repeat_o <= s1_rep;
    end
  end

endmodule

// File: tb/tb_cps2_linedoubler.sv
// Directed bench for cps2_linedoubler: drives 1024-clock frontend lines and
// checks doubling, banking, scanlines, vsync, freewheel, truncation and reset.
`timescale 1ns/1ps
module tb_cps2_linedoubler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] r_i = '0, g_i = '0, b_i = '0, f_i = '0;
  logic       hs_i = 1'b1, vs_i = 1'b1, de_i = 1'b0;
  logic [8:0] x_i = '0;
  logic       scan = 1'b0;
  logic [3:0] r_o, g_o, b_o, f_o;
  logic       hs_o, vs_o, de_o, rep_o;
  logic [8:0] x_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int line_start = 0;

  // Statistics gathered by the output monitor.
  int de_cnt, de_runs, de_idx, run_bad, px_err;
  int hs_falls, first_off, first_gap, last_fall = -1, period_bad;
  int vs_low_cnt, vs_falls, vs_aligned;
  logic        de_prev = 1'b0, hs_prev = 1'b1, vs_prev = 1'b1;
  logic        exp_ramp = 1'b1;
  logic [15:0] exp_val = '0;
  logic [15:0] exp_px;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cps2_linedoubler dut (
    .PCLK2x_i      (clk),
    .RESET_N_i     (rst_n),
    .R_i           (r_i),
    .G_i           (g_i),
    .B_i           (b_i),
    .F_i           (f_i),
    .HSYNC_i       (hs_i),
    .VSYNC_i       (vs_i),
    .DE_i          (de_i),
    .xpos_i        (x_i),
    .scanline_en_i (scan),
    .R_o           (r_o),
    .G_o           (g_o),
    .B_o           (b_o),
    .F_o           (f_o),
    .HSYNC_o       (hs_o),
    .VSYNC_o       (vs_o),
    .DE_o          (de_o),
    .xpos_o        (x_o),
    .repeat_o      (rep_o)
  );

  // Output monitor: the first DE run of a line is replay 0, the second replay 1.
  always @(negedge clk) begin
    if (de_o === 1'b1) begin
      if (!de_prev) begin
        de_runs++;
        de_idx = 0;
      end
      exp_px = (scan && de_runs == 2) ? 16'h0000 : (exp_ramp ? 16'(de_idx) : exp_val);
      if ({r_o, g_o, b_o, f_o} !== exp_px || x_o !== 9'(de_idx) || rep_o !== (de_runs == 2))
        px_err++;
      de_idx++;
      de_cnt++;
    end else if (de_prev && de_idx != 384) begin
      run_bad++;
    end
    de_prev = (de_o === 1'b1);
    if (hs_prev === 1'b1 && hs_o === 1'b0) begin
      if (hs_falls == 0) begin
        first_off = cyc - line_start;
        first_gap = (last_fall >= 0) ? cyc - last_fall : -1;
      end
      hs_falls++;
      if (last_fall >= 0 && cyc - last_fall != 512) period_bad++;
      last_fall = cyc;
      if (vs_prev === 1'b1 && vs_o === 1'b0) vs_aligned++;
    end
    if (vs_prev === 1'b1 && vs_o === 1'b0) vs_falls++;
    if (vs_o === 1'b0) vs_low_cnt++;
    hs_prev = hs_o;
    vs_prev = vs_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives clocks first_c..last_c of a 1024-clock frontend line.
  // mode 0 = pixel equals xpos, otherwise constant val.
  task automatic applyStimulus(input int mode, input logic [15:0] val, input bit hs_en,
                               input bit vs_low, input int first_c, input int last_c);
    logic [15:0] px;
    for (int c = first_c; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        line_start = cyc;
        de_cnt = 0; de_runs = 0; run_bad = 0; px_err = 0;
        hs_falls = 0; first_off = -1; first_gap = -1;
      end
      hs_i = !(hs_en && c < 72);
      vs_i = !vs_low;
      if (c >= 194 && c <= 961) begin
        de_i = 1'b1;
        x_i  = 9'((c - 194) / 2);
        px   = (mode == 0) ? 16'(x_i) : val;
      end else if (c >= 962 && c <= 979) begin
        de_i = 1'b1;
        x_i  = 9'(384 + (c - 962));
        px   = 16'hFFFF;
      end else begin
        de_i = 1'b0;
        x_i  = '0;
        px   = '0;
      end
      if (!hs_en) de_i = 1'b0;
      {r_i, g_i, b_i, f_i} = px;
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hsync", hs_o, 1);
    checkOutput("rst_vsync", vs_o, 1);
    checkOutput("rst_de", de_o, 0);
    checkOutput("rst_rgbf", {r_o, g_o, b_o, f_o}, 0);
    checkOutput("rst_xpos", x_o, 0);
    checkOutput("rst_repeat", rep_o, 0);
    rst_n = 1'b1;

    applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("first_line_no_de", de_cnt, 0);

    exp_ramp = 1'b1; last_fall = -1; period_bad = 0;
    applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("basic_de_cycles", de_cnt, 768);
    checkOutput("basic_runs", de_runs, 2);
    checkOutput("basic_run_len", run_bad, 0);
    checkOutput("basic_pixels", px_err, 0);
    checkOutput("basic_hs_falls", hs_falls, 2);
    checkOutput("basic_hs_offset", first_off, 3);

    applyStimulus(1, 16'hAAAA, 1, 0, 0, 1023);
    checkOutput("bank_ramp_pixels", px_err, 0);
    exp_ramp = 1'b0; exp_val = 16'hAAAA;
    applyStimulus(1, 16'h5555, 1, 0, 0, 1023);
    checkOutput("bank_aaaa_pixels", px_err, 0);
    checkOutput("bank_aaaa_de", de_cnt, 768);
    exp_val = 16'h5555;
    applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("bank_5555_pixels", px_err, 0);
    checkOutput("hs_period", period_bad, 0);

    scan = 1'b1; exp_ramp = 1'b1;
    applyStimulus(1, 16'h0F0F, 1, 0, 0, 1023);
    checkOutput("scan_ramp_pixels", px_err, 0);
    checkOutput("scan_de_cycles", de_cnt, 768);
    exp_ramp = 1'b0; exp_val = 16'h0F0F;
    applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("scan_0f0f_pixels", px_err, 0);
    scan = 1'b0;

    exp_ramp = 1'b1; vs_low_cnt = 0; vs_falls = 0; vs_aligned = 0;
    applyStimulus(0, 16'h0, 1, 1, 0, 1023);
    for (int l = 0; l < 3; l++) applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("vsync_low_cycles", vs_low_cnt, 3072);
    checkOutput("vsync_falls", vs_falls, 1);
    checkOutput("vsync_aligned", vs_aligned, 1);
    checkOutput("vsync_pixels", px_err, 0);

    applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("pre_free_de", de_cnt, 768);
    last_fall = -1; period_bad = 0;
    applyStimulus(0, 16'h0, 0, 0, 0, 1023);
    checkOutput("free_no_de", de_cnt, 0);
    checkOutput("free_hs_falls", hs_falls, 2);
    checkOutput("free_period", period_bad, 0);
    checkOutput("free_hs_offset", first_off, 3);
    applyStimulus(0, 16'h0, 0, 0, 0, 200);
    applyStimulus(0, 16'h0, 1, 0, 0, 1023);
    checkOutput("trunc_gap", first_gap, 201);
    checkOutput("trunc_hs_offset", first_off, 3);
    checkOutput("trunc_de", de_cnt, 768);
    checkOutput("trunc_pixels", px_err, 0);

    applyStimulus(0, 16'h0, 1, 0, 0, 699);
    @(negedge clk);
    checkOutput("pre_reset_de", de_o, 1);
    checkOutput("pre_reset_repeat", rep_o, 1);
    rst_n = 1'b0;
    applyStimulus(0, 16'h0, 1, 0, 700, 700);
    @(negedge clk);
    checkOutput("midrst_de", de_o, 0);
    checkOutput("midrst_repeat", rep_o, 0);
    checkOutput("midrst_xpos", x_o, 0);
    checkOutput("midrst_rgbf", {r_o, g_o, b_o, f_o}, 0);
    checkOutput("midrst_hsync", hs_o, 1);
    checkOutput("midrst_vsync", vs_o, 1);
    applyStimulus(0, 16'h0, 1, 0, 701, 701);
    rst_n = 1'b1;
    applyStimulus(0, 16'h0, 1, 0, 702, 1023);
    applyStimulus(1, 16'h1234, 1, 0, 0, 1023);
    checkOutput("post_rst_no_de", de_cnt, 0);
    exp_ramp = 1'b0; exp_val = 16'h1234; last_fall = -1; period_bad = 0;
    applyStimulus(1, 16'h4321, 1, 0, 0, 1023);
    checkOutput("post_rst_de", de_cnt, 768);
    checkOutput("post_rst_runs", de_runs, 2);
    checkOutput("post_rst_pixels", px_err, 0);
    checkOutput("post_rst_period", period_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
